// File: rtl/fphub_sqrt_arbiter_if.sv
// Requester-side bus of the sqrt arbiter: per-requester request and response
// handshakes plus the shared response payload.
interface fphub_sqrt_arbiter_if #(
   parameter int N = 4,
   parameter int W = 32
);
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_x;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   rsp_valid;
   logic [N-1:0]   rsp_ready;
   logic [W-1:0]   rsp_data;
   logic           rsp_err;

   modport master (
      output req_valid, req_x, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, req_x, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/fphub_sqrt_arbiter.sv
// Round-robin arbiter sharing one FPHUB_sqrt unit among N requesters, with a
// watchdog that answers with an error response when the unit never finishes.
module fphub_sqrt_arbiter #(
   parameter int N       = 4,
   parameter int W       = 32,
   parameter int TIMEOUT = 64,
   localparam int IW     = (N > 1) ? $clog2(N) : 1,
   localparam int CW     = $clog2(TIMEOUT) + 1
) (
   input  logic                 clk,
   input  logic                 rst_l,
   fphub_sqrt_arbiter_if.slave  req,
   output logic                 busy,
   output logic [IW-1:0]        grant_id,
   output logic                 sq_start,
   output logic [W-1:0]         sq_x,
   input  logic [W-1:0]         sq_res,
   input  logic                 sq_finish,
   input  logic                 sq_computing
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t          state_reg;
   logic [IW-1:0]   ptr_reg;
   logic [IW-1:0]   grant_reg;
   logic [CW-1:0]   cnt_reg;
   logic            busy_reg;
   logic            sq_start_reg;
   logic [W-1:0]    sq_x_reg;
   logic [N-1:0]    rsp_valid_reg;
   logic [W-1:0]    rsp_data_reg;
   logic            rsp_err_reg;

   logic [W-1:0]    x_arr [N];
   logic            grant_found;
   logic [IW-1:0]   grant_idx;
   logic [IW-1:0]   cand;
   logic            grant_valid;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_unpack
         assign x_arr[gi] = req.req_x[gi*W +: W];
      end
   endgenerate

   // First pending requester strictly after the last served one, with wrap.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 1; k <= N; k++) begin
         cand = IW'((int'(ptr_reg) + k) % N);
         if (!grant_found && req.req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // A stale operation left running after a timeout blocks new grants.
   assign grant_valid = (state_reg == IDLE) && grant_found && !sq_computing;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_ready
         assign req.req_ready[gi] = rst_l && grant_valid && (grant_idx == IW'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_reg     <= IDLE;
         ptr_reg       <= IW'(N - 1);
         grant_reg     <= '0;
         cnt_reg       <= '0;
         busy_reg      <= 1'b0;
         sq_start_reg  <= 1'b0;
         sq_x_reg      <= '0;
         rsp_valid_reg <= '0;
         rsp_data_reg  <= '0;
         rsp_err_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (grant_valid) begin
                  sq_x_reg     <= x_arr[grant_idx];
                  grant_reg    <= grant_idx;
                  sq_start_reg <= 1'b1;
                  busy_reg     <= 1'b1;
                  state_reg    <= ISSUE;
               end
            end
            ISSUE: begin
               sq_start_reg <= 1'b0;
               cnt_reg      <= '0;
               state_reg    <= WAIT;
            end
            WAIT: begin
               cnt_reg <= cnt_reg + CW'(1);
               // A finish arriving on the last allowed cycle still counts as success.
               if (sq_finish) begin
                  rsp_data_reg  <= sq_res;
                  rsp_err_reg   <= 1'b0;
                  rsp_valid_reg <= N'(1) << grant_reg;
                  state_reg     <= RESP;
               end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
                  rsp_data_reg  <= {W{1'b1}};
                  rsp_err_reg   <= 1'b1;
                  rsp_valid_reg <= N'(1) << grant_reg;
                  state_reg     <= RESP;
               end
            end
            RESP: begin
               if (req.rsp_ready[grant_reg]) begin
                  rsp_valid_reg <= '0;
                  ptr_reg       <= grant_reg;
                  busy_reg      <= 1'b0;
                  state_reg     <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign busy          = busy_reg;
   assign grant_id      = grant_reg;
   assign sq_start      = sq_start_reg;
   assign sq_x          = sq_x_reg;
   assign req.rsp_valid = rsp_valid_reg;
   assign req.rsp_data  = rsp_data_reg;
   assign req.rsp_err   = rsp_err_reg;

   a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_l) $onehot0(req.req_ready));
   a_rsp_onehot:   assert property (@(posedge clk) disable iff (!rst_l) $onehot0(req.rsp_valid));

endmodule

// File: tb/tb_fphub_sqrt_arbiter.sv
// Scoreboard bench for fphub_sqrt_arbiter with a fixed-latency sqrt stub that
// returns x+1; expectations are queued on accept and checked on response.
module tb_fphub_sqrt_arbiter;
   localparam int N = 4;
   localparam int W = 32;

   typedef struct {
      int          id;
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_l;
   logic        busy;
   logic [1:0]  grant_id;
   logic        sq_start;
   logic [31:0] sq_x;
   logic [31:0] sq_res;
   logic        sq_finish;
   logic        sq_computing;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   acc_cyc  = 0;
   exp_t exp_q[$];

   int          stub_d    = 3;
   bit          stub_hang = 1'b0;
   bit          stub_kill = 1'b0;
   int          stub_cnt;
   logic [31:0] stub_x;

   logic [31:0] t2_x [0:4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h41000000};
   logic [31:0] t2_e [0:4] = '{32'h3F800001, 32'h40000001, 32'h40400001, 32'h40800001, 32'h41000001};

   fphub_sqrt_arbiter_if #(.N(N), .W(W)) bus ();

   fphub_sqrt_arbiter #(.N(N), .W(W), .TIMEOUT(64)) dut (
      .clk          (clk),
      .rst_l        (rst_l),
      .req          (bus),
      .busy         (busy),
      .grant_id     (grant_id),
      .sq_start     (sq_start),
      .sq_x         (sq_x),
      .sq_res       (sq_res),
      .sq_finish    (sq_finish),
      .sq_computing (sq_computing)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Sqrt stub: finish is high in cycle stub_d+2 counted from the accept cycle.
   always @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         sq_computing <= 1'b0;
         sq_finish    <= 1'b0;
         sq_res       <= '0;
         stub_cnt     <= 0;
         stub_x       <= '0;
      end else begin
         sq_finish <= 1'b0;
         if (stub_kill) begin
            sq_computing <= 1'b0;
         end else if (sq_finish) begin
            sq_computing <= 1'b0;
         end else if (sq_start && !sq_computing) begin
            sq_computing <= 1'b1;
            stub_x       <= sq_x;
            stub_cnt     <= 1;
         end else if (sq_computing && !stub_hang && stub_cnt == stub_d) begin
            sq_finish <= 1'b1;
            sq_res    <= stub_x + 32'd1;
         end else if (sq_computing) begin
            stub_cnt <= stub_cnt + 1;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops one expectation per response handshake.
   always @(negedge clk) begin
      if (rst_l) begin
         chk("req_ready_onehot0", 64'($onehot0(bus.req_ready)), 64'd1);
         if ((bus.rsp_valid & bus.rsp_ready) != '0) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL rsp_unexpected: got rsp_valid=%0h, expected no response", bus.rsp_valid);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               $display("rsp: id=%0d data=%08h err=%0b", e.id, bus.rsp_data, bus.rsp_err);
               chk("rsp_valid_id", 64'(bus.rsp_valid), 64'(1) << e.id);
               chk("rsp_data", 64'(bus.rsp_data), 64'(e.data));
               chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
            end
         end
      end
   end

   task automatic wait_cycle(input int c);
      do @(negedge clk); while (cyc < acc_cyc + c);
   endtask

   // Waits for a grant, checks it targets id, queues the expected response,
   // then drives the requester inputs that follow the accept.
   task automatic accept(input int id, input logic [31:0] x, input logic [31:0] ed, input logic ee,
                         input logic [N-1:0] nv, input logic [31:0] nx);
      int n = 0;
      @(negedge clk);
      while (bus.req_ready == '0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (bus.req_ready == '0) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: got no req_ready, expected grant to %0d", id);
      end else begin
         chk("grant_req_ready", 64'(bus.req_ready), 64'(1) << id);
         exp_q.push_back('{id, ed, ee});
         acc_cyc = cyc;
         $display("req: id=%0d x=%08h granted at cycle %0d", id, x, cyc);
      end
      @(posedge clk);
      #1;
      bus.req_valid = nv;
      bus.req_x[id*W +: W] = nx;
      @(negedge clk);
      chk("sq_start_pulse", 64'(sq_start), 64'd1);
      chk("sq_x", 64'(sq_x), 64'(x));
      chk("grant_id", 64'(grant_id), 64'(id));
      chk("busy_high", 64'(busy), 64'd1);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("drain_done", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_l = 1'b0;
      bus.req_valid = '0;
      bus.rsp_ready = '1;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_l = 1'b1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_l = 1'b0;
      bus.req_valid = 4'hF;
      bus.req_x = '0;
      bus.rsp_ready = '1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
      chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_grant_id", 64'(grant_id), 64'd0);
      chk("rst_sq_start", 64'(sq_start), 64'd0);
      chk("rst_sq_x", 64'(sq_x), 64'd0);
      bus.req_valid = '0;
      @(posedge clk);
      #1;
      rst_l = 1'b1;

      // Single request, exact latency.
      @(posedge clk);
      #1;
      bus.req_valid = 4'b0001;
      bus.req_x[0 +: W] = 32'h41100000;
      accept(0, 32'h41100000, 32'h41100001, 1'b0, 4'b0000, 32'h41100000);
      wait_cycle(2);
      chk("t1_sq_start_low", 64'(sq_start), 64'd0);
      wait_cycle(5);
      chk("t1_rsp_not_yet", 64'(bus.rsp_valid), 64'd0);
      wait_cycle(6);
      chk("t1_rsp_valid", 64'(bus.rsp_valid), 64'h1);
      wait_cycle(7);
      chk("t1_idle_again", 64'(busy), 64'd0);
      drain();

      // All four requesting continuously.
      do_reset();
      bus.req_x = {t2_x[3], t2_x[2], t2_x[1], t2_x[0]};
      bus.req_valid = 4'hF;
      accept(0, t2_x[0], t2_e[0], 1'b0, 4'hF, t2_x[4]);
      accept(1, t2_x[1], t2_e[1], 1'b0, 4'hF, t2_x[1]);
      accept(2, t2_x[2], t2_e[2], 1'b0, 4'hF, t2_x[2]);
      accept(3, t2_x[3], t2_e[3], 1'b0, 4'hF, t2_x[3]);
      accept(0, t2_x[4], t2_e[4], 1'b0, 4'h0, t2_x[4]);
      drain();

      // Backpressure on requester 2 while others wait.
      @(posedge clk);
      #1;
      bus.req_valid = 4'b0100;
      bus.req_x[2*W +: W] = 32'h40490FDB;
      accept(2, 32'h40490FDB, 32'h40490FDC, 1'b0, 4'b0000, 32'h40490FDB);
      @(posedge clk);
      #1;
      bus.rsp_ready = 4'b1011;
      bus.req_x[3*W +: W] = 32'h42C80000;
      bus.req_valid = 4'b1011;
      for (int c = 6; c < 16; c++) begin
         wait_cycle(c);
         chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'h4);
         chk("bp_rsp_data", 64'(bus.rsp_data), 64'h40490FDC);
         chk("bp_sq_start", 64'(sq_start), 64'd0);
         chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
      end
      @(posedge clk);
      #1;
      bus.rsp_ready = 4'hF;
      accept(3, 32'h42C80000, 32'h42C80001, 1'b0, 4'b0000, 32'h42C80000);
      drain();

      // Timeout: stub never finishes.
      stub_hang = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid = 4'b0001;
      bus.req_x[0 +: W] = 32'h3F800000;
      accept(0, 32'h3F800000, 32'hFFFFFFFF, 1'b1, 4'b0000, 32'h3F800000);
      wait_cycle(65);
      chk("to_rsp_not_yet", 64'(bus.rsp_valid), 64'd0);
      wait_cycle(66);
      chk("to_rsp_valid", 64'(bus.rsp_valid), 64'h1);
      chk("to_rsp_err", 64'(bus.rsp_err), 64'd1);
      @(posedge clk);
      #1;
      bus.req_valid = 4'b0010;
      bus.req_x[1*W +: W] = 32'h40A00000;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("to_no_grant_computing", 64'(bus.req_ready), 64'd0);
         chk("to_idle", 64'(busy), 64'd0);
      end
      @(posedge clk);
      #1;
      stub_hang = 1'b0;
      stub_kill = 1'b1;
      @(posedge clk);
      #1;
      stub_kill = 1'b0;
      accept(1, 32'h40A00000, 32'h40A00001, 1'b0, 4'b0000, 32'h40A00000);
      drain();

      // Reset in the middle of WAIT.
      @(posedge clk);
      #1;
      bus.req_valid = 4'b0001;
      bus.req_x[0 +: W] = 32'h40E00000;
      accept(0, 32'h40E00000, 32'h40E00001, 1'b0, 4'b0000, 32'h40E00000);
      wait_cycle(2);
      @(posedge clk);
      #1;
      rst_l = 1'b0;
      bus.req_valid = 4'b1001;
      bus.req_x[3*W +: W] = 32'h41200000;
      #1;
      exp_q.delete();
      chk("mr_busy", 64'(busy), 64'd0);
      chk("mr_sq_start", 64'(sq_start), 64'd0);
      chk("mr_sq_x", 64'(sq_x), 64'd0);
      chk("mr_grant_id", 64'(grant_id), 64'd0);
      chk("mr_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("mr_req_ready", 64'(bus.req_ready), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_l = 1'b1;
      accept(0, 32'h40E00000, 32'h40E00001, 1'b0, 4'b1000, 32'h40E00000);
      accept(3, 32'h41200000, 32'h41200001, 1'b0, 4'b0000, 32'h41200000);
      drain();

      // Finish lands exactly on the timeout cycle.
      stub_d = 63;
      @(posedge clk);
      #1;
      bus.req_valid = 4'b0001;
      bus.req_x[0 +: W] = 32'h3E800000;
      accept(0, 32'h3E800000, 32'h3E800001, 1'b0, 4'b0000, 32'h3E800000);
      wait_cycle(65);
      chk("ft_rsp_not_yet", 64'(bus.rsp_valid), 64'd0);
      wait_cycle(66);
      chk("ft_rsp_valid", 64'(bus.rsp_valid), 64'h1);
      chk("ft_rsp_err", 64'(bus.rsp_err), 64'd0);
      drain();
      stub_d = 3;

      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fphub_sqrt_arbiter.md
Name: fphub_sqrt_arbiter

Overview:
- Shares one FPHUB_sqrt unit (start/x/res/finish/computing interface) among N requesters.
- Round-robin arbitration, per-requester valid/ready request and response handshakes, and a watchdog timeout.
- Sits between the vector/scalar issue logic and the single sqrt datapath instance; shares clk and rst_l with it.

Parameters:
- N, 4, number of requesters (2..16).
- W, 32, operand/result width (HUB single precision).
- TIMEOUT, 64, maximum cycles in WAIT before forced error response (>=2).

Ports:
- clk  input  1  clock, rising edge.
- rst_l  input  1  asynchronous active-low reset.
- req_valid  input  N  requester i has an operand pending.
- req_x  input  N*W  operands; requester i at bits [i*W +: W].
- req_ready  output  N  one-hot accept; request i is consumed when req_valid[i] and req_ready[i] are both high.
- rsp_valid  output  N  one-hot; result pending for requester i.
- rsp_ready  input  N  requester i accepts its response.
- rsp_data  output  W  result, shared by all requesters, qualified by rsp_valid.
- rsp_err  output  1  response produced by timeout, qualified by rsp_valid.
- busy  output  1  high in every state except IDLE.
- grant_id  output  clog2(N)  index of current owner, valid while busy.
- sq_start  output  1  start pulse to the sqrt unit.
- sq_x  output  W  operand to the sqrt unit, registered.
- sq_res  input  W  sqrt result.
- sq_finish  input  1  sqrt done pulse.
- sq_computing  input  1  sqrt unit is busy.

Behaviour:
- Reset (async, rst_l=0): state=IDLE; req_ready, rsp_valid, rsp_data, rsp_err, busy, grant_id, sq_start and sq_x all 0; timeout counter 0; rr pointer=N-1, so requester 0 has top priority first.
- Reset mid-operation aborts the transaction with no response; the sqrt unit is reset by the same rst_l.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, grant: if any req_valid and sq_computing=0, g = first set index searching (ptr+1) mod N upward with wrap.
  - req_ready[g]=1 combinationally that cycle; at most one bit set.
  - Clock edge: sq_x<=req_x[g], grant_id<=g, -> ISSUE.
- IDLE, no grant: if sq_computing=1 (stale op after a timeout), no grant; req_ready=0.
- ISSUE: sq_start=1 for exactly one cycle; sq_x held; counter cleared; -> WAIT.
- WAIT: sq_start=0 and the counter increments each cycle.
  - If sq_finish=1: rsp_data<=sq_res, rsp_err<=0, -> RESP.
  - Else if counter==TIMEOUT-1: rsp_data<={W{1'b1}}, rsp_err<=1, -> RESP.
  - If sq_finish coincides with the timeout cycle, finish wins (rsp_err=0).
- RESP: rsp_valid[grant_id]=1; rsp_data and rsp_err stable until handshake.
  - On rsp_ready[grant_id]: ptr<=grant_id, -> IDLE.
  - rsp_ready bits of other requesters are ignored.
- sq_finish outside WAIT is ignored; no result is captured.
- sq_x changes only on the IDLE->ISSUE edge.
- Latency with no backpressure: accept at cycle 0, sq_start at 1, sq_finish at k, rsp_valid from k+1, earliest next accept at k+2 (IDLE re-entered at k+2).
- Throughput: one operation in flight; no queueing inside the block.
- Requester i may drop req_valid before being granted; no grant is made to it.
- A requester that still has req_valid high while its rsp_valid is pending is not re-arbitrated until RESP completes.

Test Plan:
- Bench uses a sqrt stub: latency L=5, returns x+1, computing high start..finish.
- Single request: req_valid=4'b0001, req_x[0]=32'h41100000 -> req_ready[0] at c0, sq_start at c1, sq_x=32'h41100000, rsp_valid[0] at c6, rsp_data=32'h41100001, rsp_err=0.
- All four requesting continuously, rsp_ready=1 -> grant order 0,1,2,3,0, each rsp_data=own x+1, never two req_ready bits high.
- Backpressure: hold rsp_ready[2]=0 for 10 cycles -> rsp_valid[2] and rsp_data stay stable, no sq_start, no other req_ready until acceptance.
- Timeout: stub never finishes, TIMEOUT=64 -> rsp_err=1, rsp_data=32'hFFFFFFFF, rsp_valid at cycle 66 after accept; no new grant while sq_computing=1.
- Reset mid-WAIT: drop rst_l at cycle 3 -> all outputs 0 immediately; after release, requester 0 wins over simultaneous requester 3.
- Finish on timeout cycle: sq_finish at counter==TIMEOUT-1 -> rsp_err=0, rsp_data=x+1.
